// File: rtl/mru_pkg.sv
// Shared types and constants for the mru_arb Wishbone requester arbiter.
package mru_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } mru_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width that stays legal for a single-port build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mru_arb_if.sv
// Wishbone master bus bundle; mru_arb drives it through the master modport.
interface mru_arb_if #(
  parameter int DW = 32,
  parameter int AW = 30
);
  logic [AW-1:0]   adr_o;
  logic [DW-1:0]   dat_o;
  logic [DW/8-1:0] sel_o;
  logic            we_o;
  logic            cyc_o;
  logic            stb_o;
  logic [DW-1:0]   dat_i;
  logic            ack_i;
  logic            err_i;

  modport master (
    output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/mru_pick.sv
// Combinational winner selector: fixed priority (lowest index) or round-robin
// starting just after last_grant.
module mru_pick #(
  parameter int NPORTS = 2,
  parameter int IW     = 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     last_grant,
  input  logic              mode,
  output logic [NPORTS-1:0] gnt,
  output logic [IW-1:0]     gnt_idx,
  output logic              gnt_vld
);

  always_comb begin
    logic [IW-1:0] cand;
    cand    = '0;
    gnt_idx = '0;
    gnt     = '0;
    gnt_vld = |req;
    if (mode) begin
      // Walk the ring backwards so the closest port after last_grant is kept.
      for (int k = NPORTS; k >= 1; k--) begin
        cand = IW'((int'(last_grant) + k) % NPORTS);
        if (req[cand]) gnt_idx = cand;
      end
    end else begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (req[i]) gnt_idx = IW'(i);
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mru_arb.sv
// Multi-requester to single Wishbone master arbiter, one bus cycle at a time.
// Optional bus watchdog enabled by defining MRU_TIMEOUT_EN.
module mru_arb
  import mru_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int DW       = 32,
  parameter int AW       = 30,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int TIMEOUT  = 255
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic [NPORTS-1:0]      req_en,
  input  logic [NPORTS*AW-1:0]   req_adr,
  input  logic [NPORTS-1:0]      req_we,
  input  logic [NPORTS*DW/8-1:0] req_sel,
  input  logic [NPORTS*DW-1:0]   req_dat,
  output logic [NPORTS-1:0]      req_stl,
  output logic [NPORTS-1:0]      req_ack,
  output logic [NPORTS-1:0]      req_err,
  output logic [DW-1:0]          res_dat,
  mru_arb_if.master              wb,
  output mru_state_e             dbg_state
);

  localparam int IW = idx_w(NPORTS);
  localparam int SW = DW / 8;

  if (NPORTS < 1 || NPORTS > 8 || DW % 8 != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mru_arb: unsupported parameter set");
  end

  // Handshake: a port's request is taken on the clock edge where req_en=1 and
  // req_stl=0; completion is a single-cycle req_ack or req_err pulse.
  mru_state_e        state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic [DW-1:0]     res_q, res_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic [NPORTS-1:0] err_q, err_d;

`ifdef MRU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     cnt_q, cnt_d;
`endif

  logic [NPORTS-1:0] gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic              can_grant;
  logic [AW-1:0]     g_adr;
  logic [DW-1:0]     g_dat;
  logic [SW-1:0]     g_sel;
  logic              g_we;

  mru_pick #(.NPORTS(NPORTS), .IW(IW)) u_pick (
    .req        (req_en),
    .last_grant (last_q),
    .mode       (ARB_MODE == ARB_RR),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_vld    (gnt_vld)
  );

  // rdy_q holds off granting on the first edge after reset release.
  assign can_grant = (state_q == ST_IDLE) && rdy_q && gnt_vld;
  assign req_stl   = req_en & ~(can_grant ? gnt : '0);

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (gnt[i]) begin
        g_adr = req_adr[i*AW +: AW];
        g_dat = req_dat[i*DW +: DW];
        g_sel = req_sel[i*SW +: SW];
        g_we  = req_we[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    last_d  = last_q;
    gidx_d  = gidx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    res_d   = res_q;
    ack_d   = '0;
    err_d   = '0;
`ifdef MRU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          state_d = ST_BUS;
          last_d  = gnt_idx;
          gidx_d  = gnt_idx;
          adr_d   = g_adr;
          dat_d   = g_dat;
          sel_d   = g_sel;
          we_d    = g_we;
          cyc_d   = 1'b1;
`ifdef MRU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUS: begin
        if (wb.err_i) begin
          state_d        = ST_IDLE;
          cyc_d          = 1'b0;
          err_d[gidx_q]  = 1'b1;
        end else if (wb.ack_i) begin
          state_d        = ST_IDLE;
          cyc_d          = 1'b0;
          res_d          = wb.dat_i;
          ack_d[gidx_q]  = 1'b1;
        end
`ifdef MRU_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d        = ST_IDLE;
          cyc_d          = 1'b0;
          err_d[gidx_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      last_q  <= IW'(NPORTS - 1);
      gidx_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      res_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
`ifdef MRU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef MRU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wb.adr_o  = adr_q;
  assign wb.dat_o  = dat_q;
  assign wb.sel_o  = sel_q;
  assign wb.we_o   = we_q;
  assign wb.cyc_o  = cyc_q;
  assign wb.stb_o  = cyc_q;
  assign res_dat   = res_q;
  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mru_arb.sv
// Bench for mru_arb: a 2-port fixed-priority instance (watchdog 16) and a
// 4-port round-robin instance, with queue-based completion checking.
module tb_mru_arb;
  import mru_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 ports, fixed priority
  logic [1:0]  a_req_en, a_req_we, a_stl, a_ack, a_err;
  logic [59:0] a_req_adr;
  logic [7:0]  a_req_sel;
  logic [63:0] a_req_dat;
  logic [31:0] a_res;
  mru_state_e  a_state;
  mru_arb_if #(.DW(32), .AW(30)) wb_a ();

  mru_arb #(.NPORTS(2), .DW(32), .AW(30), .ARB_MODE(ARB_FIXED), .TIMEOUT(16)) dut_a (
    .cpu_clk (clk), .cpu_rst (rst_n),
    .req_en (a_req_en), .req_adr (a_req_adr), .req_we (a_req_we),
    .req_sel (a_req_sel), .req_dat (a_req_dat),
    .req_stl (a_stl), .req_ack (a_ack), .req_err (a_err),
    .res_dat (a_res), .wb (wb_a.master), .dbg_state (a_state)
  );

  // Instance B: 4 ports, round-robin
  logic [3:0]   b_req_en, b_req_we, b_stl, b_ack, b_err;
  logic [119:0] b_req_adr;
  logic [15:0]  b_req_sel;
  logic [127:0] b_req_dat;
  logic [31:0]  b_res;
  mru_state_e   b_state;
  mru_arb_if #(.DW(32), .AW(30)) wb_b ();

  mru_arb #(.NPORTS(4), .DW(32), .AW(30), .ARB_MODE(ARB_RR)) dut_b (
    .cpu_clk (clk), .cpu_rst (rst_n),
    .req_en (b_req_en), .req_adr (b_req_adr), .req_we (b_req_we),
    .req_sel (b_req_sel), .req_dat (b_req_dat),
    .req_stl (b_stl), .req_ack (b_ack), .req_err (b_err),
    .res_dat (b_res), .wb (wb_b.master), .dbg_state (b_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected completions: {is_err, port[2:0], res_dat[31:0]}
  logic [35:0] exp_a_q[$];
  logic [35:0] exp_b_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_a(input int p, input logic [29:0] adr, input logic we,
                       input logic [3:0] sel, input logic [31:0] dat);
    a_req_adr[p*30 +: 30] = adr;
    a_req_we[p]           = we;
    a_req_sel[p*4 +: 4]   = sel;
    a_req_dat[p*32 +: 32] = dat;
  endtask

  // Completion monitors
  logic [35:0] mon_a_act, mon_a_exp, mon_b_act, mon_b_exp;
  int          mon_a_p, mon_b_p;

  always @(negedge clk) begin
    if (rst_n && (|a_ack || |a_err)) begin
      mon_a_p = 7;
      if ($countones({a_ack, a_err}) == 1)
        for (int i = 0; i < 2; i++) if (a_ack[i] || a_err[i]) mon_a_p = i;
      mon_a_act = {|a_err, 3'(mon_a_p), a_res};
      n_tests++;
      if (exp_a_q.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_pulse: got %0h expected none", mon_a_act);
      end else begin
        mon_a_exp = exp_a_q.pop_front();
        if (mon_a_act !== mon_a_exp) begin
          n_fail++;
          $display("FAIL a_completion: got %0h expected %0h", mon_a_act, mon_a_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (|b_ack || |b_err)) begin
      mon_b_p = 7;
      if ($countones({b_ack, b_err}) == 1)
        for (int i = 0; i < 4; i++) if (b_ack[i] || b_err[i]) mon_b_p = i;
      mon_b_act = {|b_err, 3'(mon_b_p), b_res};
      n_tests++;
      if (exp_b_q.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_pulse: got %0h expected none", mon_b_act);
      end else begin
        mon_b_exp = exp_b_q.pop_front();
        if (mon_b_act !== mon_b_exp) begin
          n_fail++;
          $display("FAIL b_completion: got %0h expected %0h", mon_b_act, mon_b_exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int w;
    int n;
    rst_n = 1'b0;
    a_req_en = '0; a_req_we = '0; a_req_adr = '0; a_req_sel = '0; a_req_dat = '0;
    b_req_en = '0; b_req_we = '0; b_req_adr = '0; b_req_sel = '0; b_req_dat = '0;
    wb_a.dat_i = '0; wb_a.ack_i = 1'b0; wb_a.err_i = 1'b0;
    wb_b.dat_i = '0; wb_b.ack_i = 1'b0; wb_b.err_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cyc",   wb_a.cyc_o, 0);
    chk("rst_stb",   wb_a.stb_o, 0);
    chk("rst_we",    wb_a.we_o, 0);
    chk("rst_adr",   wb_a.adr_o, 0);
    chk("rst_dat",   wb_a.dat_o, 0);
    chk("rst_sel",   wb_a.sel_o, 0);
    chk("rst_res",   a_res, 0);
    chk("rst_ack",   a_ack, 0);
    chk("rst_err",   a_err, 0);
    chk("rst_state", 64'(a_state), 64'(ST_IDLE));
    chk("rst_b_cyc", wb_b.cyc_o, 0);

    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fixed priority: both request, port 0 reads 0x100
    set_a(0, 30'h100, 1'b0, 4'hF, 32'h0);
    set_a(1, 30'h200, 1'b1, 4'b0011, 32'h0000CAFE);
    a_req_en = 2'b11;
    #1;
    chk("stl_both", a_stl, 2'b10);
    @(negedge clk);
    a_req_en = 2'b10;
    chk("rd_cyc",   wb_a.cyc_o, 1);
    chk("rd_stb",   wb_a.stb_o, 1);
    chk("rd_adr",   wb_a.adr_o, 30'h100);
    chk("rd_we",    wb_a.we_o, 0);
    chk("rd_state", 64'(a_state), 64'(ST_BUS));
    wb_a.dat_i = 32'hDEADBEEF;
    wb_a.ack_i = 1'b1;
    exp_a_q.push_back({1'b0, 3'd0, 32'hDEADBEEF});
    @(negedge clk);
    wb_a.ack_i = 1'b0;
    chk("rd_cyc_drop", wb_a.cyc_o, 0);
    chk("stl_idle_p1", a_stl, 2'b00);

    // Port 1 write, held stable while stalled
    @(negedge clk);
    a_req_en = 2'b00;
    chk("wr_we",  wb_a.we_o, 1);
    chk("wr_sel", wb_a.sel_o, 4'b0011);
    chk("wr_dat", wb_a.dat_o, 32'h0000CAFE);
    chk("wr_adr", wb_a.adr_o, 30'h200);
    wb_a.dat_i = 32'h0BADF00D;
    wb_a.ack_i = 1'b1;
    exp_a_q.push_back({1'b0, 3'd1, 32'h0BADF00D});
    @(negedge clk);
    wb_a.ack_i = 1'b0;
    @(negedge clk);

    // err and ack together: err wins, res_dat keeps its value
    set_a(1, 30'h300, 1'b0, 4'hF, 32'h0);
    a_req_en = 2'b10;
    @(negedge clk);
    a_req_en = 2'b00;
    wb_a.dat_i = 32'h55555555;
    wb_a.ack_i = 1'b1;
    wb_a.err_i = 1'b1;
    exp_a_q.push_back({1'b1, 3'd1, 32'h0BADF00D});
    @(negedge clk);
    wb_a.ack_i = 1'b0;
    wb_a.err_i = 1'b0;
    @(negedge clk);

    // Stray ack outside BUS
    wb_a.dat_i = 32'h00000077;
    wb_a.ack_i = 1'b1;
    repeat (2) @(negedge clk);
    wb_a.ack_i = 1'b0;
    chk("stray_res",   a_res, 32'h0BADF00D);
    chk("stray_state", 64'(a_state), 64'(ST_IDLE));
    chk("stray_cyc",   wb_a.cyc_o, 0);

    // Round-robin, all four ports requesting continuously
    for (int i = 0; i < 4; i++) begin
      b_req_adr[i*30 +: 30] = 30'h10 + 30'(i);
      b_req_sel[i*4 +: 4]   = 4'hF;
    end
    for (int t = 0; t < 8; t++) exp_b_q.push_back({1'b0, 3'(t % 4), 32'hB0000000 + 32'(t)});
    b_req_en = 4'hF;
    for (int t = 0; t < 8; t++) begin
      w = 0;
      while (!wb_b.cyc_o && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("rr_wait", (w < 20), 1);
      chk("rr_adr", wb_b.adr_o, 30'h10 + 30'(t % 4));
      wb_b.dat_i = 32'hB0000000 + 32'(t);
      wb_b.ack_i = 1'b1;
      @(negedge clk);
      wb_b.ack_i = 1'b0;
      if (t == 7) b_req_en = 4'h0;
    end
    @(negedge clk);

    // Bus watchdog
    set_a(0, 30'h180, 1'b0, 4'hF, 32'h0);
    a_req_en = 2'b01;
    @(negedge clk);
    a_req_en = 2'b00;
    chk("wd_cyc_up", wb_a.cyc_o, 1);
`ifdef MRU_TIMEOUT_EN
    exp_a_q.push_back({1'b1, 3'd0, 32'h0BADF00D});
    n = 0;
    while (wb_a.cyc_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wd_cycles", n, 16);
`else
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (wb_a.cyc_o) n++;
    end
    chk("no_wd_hold", n, 1000);
    wb_a.dat_i = 32'hA5A5A5A5;
    wb_a.ack_i = 1'b1;
    exp_a_q.push_back({1'b0, 3'd0, 32'hA5A5A5A5});
    @(negedge clk);
    wb_a.ack_i = 1'b0;
`endif
    @(negedge clk);

    // Reset in the middle of a bus cycle
    set_a(0, 30'h400, 1'b0, 4'hF, 32'h0);
    a_req_en = 2'b01;
    @(negedge clk);
    a_req_en = 2'b00;
    chk("ra_cyc_up", wb_a.cyc_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_cyc_drop", wb_a.cyc_o, 0);
    chk("ra_stb_drop", wb_a.stb_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    set_a(1, 30'h500, 1'b0, 4'hF, 32'h0);
    a_req_en = 2'b10;
    @(negedge clk);
    a_req_en = 2'b00;
    chk("ra_new_adr", wb_a.adr_o, 30'h500);
    chk("ra_new_cyc", wb_a.cyc_o, 1);
    wb_a.dat_i = 32'h600DCAFE;
    wb_a.ack_i = 1'b1;
    exp_a_q.push_back({1'b0, 3'd1, 32'h600DCAFE});
    @(negedge clk);
    wb_a.ack_i = 1'b0;
    repeat (2) @(negedge clk);

    chk("a_queue_drained", exp_a_q.size(), 0);
    chk("b_queue_drained", exp_b_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mru_arb.md
MRU_ARB -- requirements
Module: mru_arb

Interface
REQ-001 SHALL have parameter NPORTS, default 2: number of requester ports, range 1..8.
REQ-002 SHALL have parameter DW, default 32: Wishbone data width, a multiple of 8.
REQ-003 SHALL have parameter AW, default 30: word-address width.
REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT, default 255: bus watchdog limit in cycles, used only under REQ-031.
REQ-006 cpu_clk  in  1  sole clock; the Wishbone side also runs on it.
REQ-007 cpu_rst  in  1  asynchronous, active-low reset.
REQ-008 req_en  in  NPORTS  per-port request valid.
REQ-009 req_adr  in  NPORTS*AW  per-port word address, packed with port 0 in the LSBs.
REQ-010 req_we, req_sel, req_dat  in  NPORTS, NPORTS*DW/8, NPORTS*DW  per-port write flag, byte lanes and write data.
REQ-011 req_stl  out  NPORTS  per-port stall.
REQ-012 req_ack, req_err  out  NPORTS  per-port one-cycle completion pulses.
REQ-013 res_dat  out  DW  read data shared by all ports, valid only with the req_ack pulse.
REQ-014 adr_o, dat_o, sel_o, we_o, cyc_o, stb_o  out  Wishbone master signals, all registered.
REQ-015 dat_i, ack_i, err_i  in  Wishbone master returns.

Function
REQ-016 SHALL implement the FSM states IDLE and BUS.
REQ-017 IDLE: if any req_en is high, SHALL grant one winner per ARB_MODE, latch that port's adr/we/sel/dat onto the bus registers, and go to BUS with cyc_o=stb_o=1 from the next cycle.
REQ-018 req_stl[i] SHALL be req_en[i] AND NOT (state==IDLE AND grant==i); a request is accepted in the cycle req_en=1 and req_stl=0.
REQ-019 Each port SHALL hold its request fields stable while stalled; after acceptance it may change them.
REQ-020 BUS, ack_i=1: SHALL drop cyc_o/stb_o, register dat_i into res_dat, pulse req_ack[grant] in the next cycle, and return to IDLE.
REQ-021 BUS, err_i=1: SHALL behave as REQ-020 but pulse req_err[grant] instead, leaving res_dat unchanged.
REQ-022 If ack_i and err_i are high together, err_i SHALL take precedence.
REQ-023 Latency: request accepted at cycle 0, stb_o=1 at cycle 1; ack_i sampled at cycle k gives req_ack at cycle k+1.
REQ-024 At least one IDLE cycle SHALL separate back-to-back bus cycles; there is no pipelined mode.
REQ-025 Round-robin: the search SHALL start at last_grant+1 modulo NPORTS; last_grant is updated only on a grant.
REQ-026 ack_i or err_i received outside BUS SHALL be ignored.
REQ-027 we_o=0 cycles SHALL drive dat_o with the latched, don't-care value; sel_o SHALL pass req_sel unmodified.

Reset
REQ-028 On cpu_rst=0, asynchronously: state=IDLE, cyc_o=stb_o=we_o=0, adr_o/dat_o/sel_o/res_dat=0, req_ack=req_err=0, last_grant=NPORTS-1.
REQ-029 A reset during BUS SHALL abandon the cycle with no ack or err pulse; requesters re-issue.
REQ-030 Reset release SHALL take effect on the first cpu_clk edge with cpu_rst=1; no request is granted in that same cycle.

Configuration
REQ-031 With MRU_TIMEOUT_EN defined: a counter SHALL clear on entry to BUS and increment each BUS cycle; when it reaches TIMEOUT with neither ack_i nor err_i, the block SHALL drop cyc_o/stb_o, pulse req_err[grant], and return to IDLE.
REQ-032 Without MRU_TIMEOUT_EN: the counter SHALL NOT exist and BUS SHALL wait indefinitely for ack_i or err_i.

Structure
REQ-033 Package mru_pkg SHALL hold the FSM state enum and the ARB_MODE constants ARB_FIXED=0 and ARB_RR=1.
REQ-034 Sub-module mru_pick SHALL be a combinational winner selector taking (req, last_grant, mode) and returning a one-hot grant plus its index.

Verification
REQ-035 NPORTS=2, fixed mode: req_en=2'b11 with port 0 reading 0x100 -> port 0 is granted, adr_o=0x100, req_stl=2'b10; ack_i with dat_i=0xDEADBEEF -> next cycle req_ack=2'b01 and res_dat=0xDEADBEEF.
REQ-036 NPORTS=4, RR mode: all ports request continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Write by port 1 with sel=4'b0011 and dat=0x0000CAFE -> we_o=1, sel_o=4'b0011, dat_o=0x0000CAFE; after ack, req_ack[1] pulses for exactly one cycle.
REQ-038 err_i and ack_i asserted together in BUS -> req_err[grant] pulses and req_ack stays 0.
REQ-039 With MRU_TIMEOUT_EN and TIMEOUT=16, no ack supplied -> cyc_o falls and req_err pulses 16 cycles after stb_o rose; without the macro, cyc_o stays high for 1000 cycles.
REQ-040 cpu_rst asserted low during BUS -> cyc_o/stb_o go to 0 immediately; no ack or err pulse follows; a new request after release is granted normally.
